// File: rtl/control_eventos_teclado_if.sv
// rtl/control_eventos_teclado_if.sv - PicoBlaze port/interrupt bus seen by the keyboard event controller
interface control_eventos_teclado_if;
  logic [7:0] Port_ID;
  logic       read_strobe;
  logic       interrupt_ack;
  logic [7:0] In_Port;
  logic       interrupt;

  modport master (
    output Port_ID, read_strobe, interrupt_ack,
    input  In_Port, interrupt
  );

  modport slave (
    input  Port_ID, read_strobe, interrupt_ack,
    output In_Port, interrupt
  );
endinterface

// File: rtl/control_eventos_teclado.sv
// rtl/control_eventos_teclado.sv - debounced push-button events queued for PicoBlaze with interrupt handshake
module control_eventos_teclado #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic aumenta,
  input  logic disminuye,
  input  logic siguiente,
  input  logic anterior,
  input  logic cambia,
  control_eventos_teclado_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [4:0]    DEPTH    = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD} state_t;

  // bit order: 0 aumenta, 1 disminuye, 2 siguiente, 3 anterior, 4 cambia
  logic [4:0]    raw, sync1, sync2, stable, pending, press, grant;
  logic [CW-1:0] cnt [5];
  logic [7:0]    push_code;
  logic          push, pop, drop, wr, full, empty, rd_port, st_port;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    count, count_next;
  logic          overflow;
  state_t        state, state_next;
  logic          irq_q;

  assign raw = {cambia, anterior, siguiente, disminuye, aumenta};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_comb begin
    press = '0;
    for (int i = 0; i < 5; i++) begin
      press[i] = sync2[i] & ~stable[i] & (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // priority cambia > aumenta > disminuye > siguiente > anterior
  always_comb begin
    grant     = '0;
    push_code = 8'h00;
    if (pending[4]) begin
      grant[4] = 1'b1; push_code = 8'h09;
    end else if (pending[0]) begin
      grant[0] = 1'b1; push_code = 8'h04;
    end else if (pending[1]) begin
      grant[1] = 1'b1; push_code = 8'h05;
    end else if (pending[2]) begin
      grant[2] = 1'b1; push_code = 8'h06;
    end else if (pending[3]) begin
      grant[3] = 1'b1; push_code = 8'h07;
    end
  end

  assign push = |pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= (pending & ~grant) | press;
  end

  assign full       = (count == DEPTH);
  assign empty      = (count == 5'd0);
  assign rd_port    = (bus.Port_ID == 8'h03);
  assign st_port    = (bus.Port_ID == 8'h08);
  assign pop        = bus.read_strobe & rd_port & ~empty;
  assign drop       = push & full & ~pop;
  assign wr         = push & ~drop;
  assign count_next = count + {4'b0, wr} - {4'b0, pop};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      count    <= count_next;
      overflow <= drop | (overflow & ~(bus.read_strobe & st_port));
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= push_code;
  end

  always_comb begin
    bus.In_Port = 8'h00;
    if (rd_port && !empty) bus.In_Port = mem[rd_ptr];
    else if (st_port)      bus.In_Port = {3'b000, overflow, count[3:0]};
  end

  // a pop while still in REQ (polling without ack) only leaves REQ once the queue drains
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!empty) state_next = REQ;
      REQ:     if (bus.interrupt_ack) state_next = WAIT_RD;
               else if (count_next == 5'd0) state_next = IDLE;
      WAIT_RD: if (pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      irq_q <= 1'b0;
    end else begin
      state <= state_next;
      irq_q <= (state_next == REQ);
    end
  end

  assign bus.interrupt = irq_q;

endmodule

// File: doc/control_eventos_teclado.md
Name: control_eventos_teclado

Overview:
- Event controller between the five raw push-buttons (aumenta, disminuye, siguiente, anterior, cambia) and the PicoBlaze input port.
- Synchronises and debounces each button and turns each press into one event code.
- Arbitrates simultaneous presses and queues the events in a small FIFO.
- Raises an interrupt to the processor and releases each event through a port-read handshake.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); minimum 2.
- FIFO_DEPTH, 4: event queue depth; power of two, 2..16.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- aumenta  input  1  raw button, active-high, asynchronous to clk.
- disminuye  input  1  raw button.
- siguiente  input  1  raw button.
- anterior  input  1  raw button.
- cambia  input  1  raw button.
- Port_ID  input  8  PicoBlaze port address.
- read_strobe  input  1  PicoBlaze read strobe, one cycle.
- interrupt_ack  input  1  PicoBlaze interrupt acknowledge, one cycle.
- In_Port  output  8  read data to PicoBlaze, combinational from Port_ID.
- interrupt  output  1  interrupt request, registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - Clears synchronisers, debounce counters, stable states, pending bits, FIFO pointers, count and overflow flag.
  - interrupt=0, FSM=IDLE, In_Port reads 0x00 on every port.
- Synchroniser: two flops per button. Only the synchronised level is used downstream.
- Debounce, per button:
  - Counter resets whenever the synchronised level equals the stable state.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the stable state takes the new level and the counter clears.
  - A 0->1 stable transition is a press event. Release produces nothing.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Pending bits:
  - A press sets that button's pending bit.
  - A second press while the bit is still set merges into it (one event).
- Arbitration:
  - Each cycle, at most one pending bit is pushed into the FIFO and cleared.
  - Fixed priority: cambia > aumenta > disminuye > siguiente > anterior.
  - Push occurs the cycle after the bit is set.
- Event codes: aumenta 0x04, disminuye 0x05, siguiente 0x06, anterior 0x07, cambia 0x09.
- FIFO:
  - Depth FIFO_DEPTH, pointers wrap modulo depth.
  - Push while full with no pop in the same cycle: event dropped, pending bit still cleared, overflow flag set (sticky).
  - Simultaneous push and pop while full: both performed, count unchanged, no overflow.
  - Pop while empty: ignored.
- Read ports (In_Port, combinational):
  - Port_ID=0x03: head event code, or 0x00 if empty.
  - Port_ID=0x08: status = {3'b000, overflow, count[3:0]}.
  - Any other Port_ID: 0x00.
  - Pop: read_strobe=1 with Port_ID=0x03 and FIFO non-empty; effective at the clock edge.
  - Overflow clear: read_strobe=1 with Port_ID=0x08; if an overflow occurs in the same cycle, set wins.
- Interrupt FSM:
  - IDLE: if FIFO non-empty, go to REQ and drive interrupt=1 from the next cycle.
  - REQ: interrupt=1 held until interrupt_ack=1, then interrupt=0 next cycle and go to WAIT_RD.
  - WAIT_RD: wait for a pop of port 0x03, then go to IDLE. If the FIFO is still non-empty, interrupt re-asserts one cycle later (one interrupt per event).
  - A pop while in REQ (polling without ack) is allowed. FSM stays in REQ; if the FIFO becomes empty, go to IDLE and drop interrupt.
- Latency: raw rising edge to interrupt=1 is 2 (sync) + DEBOUNCE_CYCLES (debounce) + 1 (push) + 1 (FSM) cycles, for a lone press with empty FIFO and FSM in IDLE.
- Reset mid-operation: queued and pending events are lost. A button still held after reset release is treated as a new press once debounced.

Test Plan:
- Single press (DEBOUNCE_CYCLES=4): hold aumenta high for 20 cycles -> interrupt rises exactly 8 cycles after the raw edge; port 0x03 reads 0x04. After ack and read_strobe@0x03, port 0x03 reads 0x00 and status reads 0x00.
- Bounce rejection: toggle disminuye at 1-cycle intervals for 10 cycles, then drop low -> no event, status stays 0x00, interrupt stays 0.
- Simultaneous presses: assert anterior, siguiente and cambia in the same cycle and hold -> FIFO order 0x09, 0x06, 0x07 on successive pops. Exactly three interrupt/ack cycles; status count goes 3,2,1,0.
- Overflow (FIFO_DEPTH=4): generate 5 presses with no reads -> status = 0x14 (overflow=1, count=4). Events 1-4 retained in order. Reading status once, then again, gives 0x14 then 0x04.
- Full push+pop: FIFO full, a new press is pushed in the same cycle as read_strobe@0x03 -> count stays 4, overflow stays 0, new code appears as the last entry.
- Reset mid-operation: two events queued and interrupt=1, pulse reset low for 3 cycles -> interrupt=0 immediately (asynchronously), In_Port 0x00 on 0x03 and 0x08. A button still held is re-reported 0x04 after the debounce latency.
